// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader: FSM state encoding and
// the burst-length legality check used when elaborating the reader.
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // A burst must hold at least one word and never more than the FIFO can store.
  function automatic bit burst_len_legal(input int burst_len, input int addr_width);
    return (burst_len >= 32'sd1) && (burst_len <= (32'sd1 << addr_width));
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Output holding register for the burst stream: loads a popped word and keeps
// data/valid/last stable until the downstream side accepts it.
module stream_out_reg
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  accept,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last
);

  logic [DATA_WIDTH-1:0] data_r;
  logic                  valid_r;
  logic                  last_r;

  // Beat register: a load always wins over an accept so back-to-back beats flow.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r  <= {DATA_WIDTH{1'b0}};
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else if (load) begin
      data_r  <= load_data;
      valid_r <= 1'b1;
      last_r  <= load_last;
    end else if (valid_r && accept) begin
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      data_r  <= data_r;
      valid_r <= valid_r;
      last_r  <= last_r;
    end
  end

  assign out_data  = data_r;
  assign out_valid = valid_r;
  assign out_last  = last_r;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops bursts from a first-word-fall-through FIFO, either when a threshold
// is reached or when a flush asks to drain what is currently stored.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic                  fifo_full,
  input  logic [ADDR_WIDTH-1:0] fifo_depth,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_ren,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam bit BURST_LEN_OK = burst_len_legal(BURST_LEN, ADDR_WIDTH);
  // An illegal BURST_LEN degrades to single-word bursts instead of hanging.
  localparam logic [CW-1:0] BURST_CNT = BURST_LEN_OK ? CW'(BURST_LEN) : CW'(1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(1 << ADDR_WIDTH);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   target_r;
  logic [CW-1:0]   target_nxt_s;
  logic [CW-1:0]   depth_ext_s;
  logic            start_s;
  logic            ren_s;
  logic            last_beat_s;
  logic            accept_s;
  logic            out_valid_s;
  logic            out_last_s;

  assign depth_ext_s = {1'b0, fifo_depth};
  assign accept_s    = out_valid_s && out_ready;
  assign last_beat_s = ((count_r + CW'(1)) == target_r);
  assign ren_s       = (state_r == ST_XFER) && !fifo_empty && (count_r < target_r) &&
                       (!out_valid_s || out_ready) && !reset;

  // Next-state and burst-size decision; flush outranks the threshold.
  always_comb begin
    state_nxt_s  = state_r;
    target_nxt_s = target_r;
    start_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (flush && !fifo_empty) begin
          start_s      = 1'b1;
          target_nxt_s = fifo_full ? FULL_CNT : depth_ext_s;
          state_nxt_s  = ST_XFER;
        end else if (fifo_full || (depth_ext_s >= BURST_CNT)) begin
          start_s      = 1'b1;
          target_nxt_s = BURST_CNT;
          state_nxt_s  = ST_XFER;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (ren_s && last_beat_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_XFER;
        end
      end
      ST_DRAIN: begin
        if (accept_s && out_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Burst target and beat counter; the counter restarts on every burst entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r  <= {CW{1'b0}};
      target_r <= {CW{1'b0}};
    end else if (start_s) begin
      count_r  <= {CW{1'b0}};
      target_r <= target_nxt_s;
    end else if (ren_s) begin
      count_r  <= count_r + CW'(1);
      target_r <= target_r;
    end else begin
      count_r  <= count_r;
      target_r <= target_r;
    end
  end

  stream_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (ren_s),
    .accept    (out_ready),
    .load_data (fifo_data),
    .load_last (last_beat_s),
    .out_data  (out_data),
    .out_valid (out_valid_s),
    .out_last  (out_last_s)
  );

  assign fifo_ren  = ren_s;
  assign out_valid = out_valid_s;
  assign out_last  = out_last_s;
  assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-backed FIFO, a transaction-level burst
// model, a start-decision vector table, directed corner cases and random traffic.
module tb_fifo_burst_reader;

  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int BL  = 4;
  localparam int CAP = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty;
  logic          fifo_full;
  logic [AW-1:0] fifo_depth;
  logic [DW-1:0] fifo_data;
  logic          fifo_ren;
  logic          flush;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_depth(fifo_depth), .fifo_data(fifo_data), .fifo_ren(fifo_ren),
    .flush(flush), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] popped[$];
  logic [DW-1:0] acc_data[$];
  bit  m_idle = 1'b1;
  int  m_left = 0;
  int  beats_seen = 0;
  int  last_idx = 0;
  int  word_id = 0;

  logic          s_ren = 1'b0, s_valid = 1'b0, s_ready = 1'b0, s_last = 1'b0;
  logic          s_flush = 1'b0, s_reset = 1'b0;
  logic [DW-1:0] s_data = 16'h0000;
  int            s_size = 0;

  typedef struct {
    int nwords;
    bit fl;
    bit exp_busy;
    int exp_len;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    int sz = fq.size();
    fifo_empty = (sz == 0);
    fifo_full  = (sz == CAP);
    fifo_depth = sz[AW-1:0];
    fifo_data  = (sz > 0) ? fq[0] : 16'h0000;
  endtask

  task automatic push_word(output logic [DW-1:0] w);
    w = DW'(32'h0000_A000 + word_id);
    word_id++;
    fq.push_back(w);
    drive_fifo();
  endtask

  // Burst-level reference: bursts start from IDLE on flush or threshold, size
  // taken from the FIFO occupancy; accepted beats must replay popped words in order.
  task automatic model_update();
    bit idle_pre = m_idle;
    logic [DW-1:0] exp_w;
    if (s_reset) begin
      m_idle = 1'b1;
      m_left = 0;
      popped.delete();
    end else begin
      if (s_valid && s_ready) begin
        chk("beat_inside_burst", {31'b0, idle_pre}, 32'd0);
        chk("beat_has_pop", {31'b0, (popped.size() > 0)}, 32'd1);
        if (!idle_pre && popped.size() > 0) begin
          exp_w = popped.pop_front();
          chk("beat_data", s_data, exp_w);
          chk("beat_last", s_last, {31'b0, (m_left == 1)});
          acc_data.push_back(s_data);
          beats_seen++;
          if (s_last) last_idx = beats_seen;
          m_left--;
          if (m_left <= 0) begin
            m_idle = 1'b1;
            chk("no_excess_pop", popped.size(), 32'd0);
          end
        end
      end
      if (s_ren) begin
        chk("pop_inside_burst", {31'b0, idle_pre}, 32'd0);
        if (fq.size() > 0) popped.push_back(fq.pop_front());
      end
      if (idle_pre) begin
        if (s_flush && s_size > 0) begin
          m_idle = 1'b0;
          m_left = s_size;
        end else if (s_size >= BL) begin
          m_idle = 1'b0;
          m_left = BL;
        end
      end
    end
  endtask

  task automatic tick();
    bit prev_stall = s_valid && !s_ready && !s_reset;
    @(negedge clk);
    chk("busy_vs_model", busy, {31'b0, !m_idle});
    chk("ren_guard", fifo_ren && (fifo_empty || reset), 32'd0);
    chk("no_pop_when_stalled", fifo_ren && out_valid && !out_ready, 32'd0);
    if (prev_stall) begin
      chk("stall_valid", out_valid, 32'd1);
      chk("stall_data", out_data, s_data);
      chk("stall_last", out_last, s_last);
    end
    s_ren = fifo_ren; s_valid = out_valid; s_ready = out_ready; s_last = out_last;
    s_data = out_data; s_flush = flush; s_reset = reset; s_size = fq.size();
    @(posedge clk);
    #1;
    model_update();
    drive_fifo();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    fq.delete();
    drive_fifo();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_until_idle(input int max, output int n);
    bit to = 1'b1;
    beats_seen = 0;
    last_idx = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (m_idle) begin
        to = 1'b0;
        break;
      end
    end
    chk("burst_timeout", {31'b0, to}, 32'd0);
    n = beats_seen;
  endtask

  initial begin
    logic [DW-1:0] a[4];
    logic [DW-1:0] b[2];
    logic [DW-1:0] w;
    int n;

    tbl[0] = '{0,  1'b1, 1'b0, 0};
    tbl[1] = '{3,  1'b1, 1'b1, 3};
    tbl[2] = '{3,  1'b0, 1'b0, 0};
    tbl[3] = '{4,  1'b0, 1'b1, 4};
    tbl[4] = '{5,  1'b1, 1'b1, 5};
    tbl[5] = '{7,  1'b0, 1'b1, 4};
    tbl[6] = '{16, 1'b0, 1'b1, 4};
    tbl[7] = '{16, 1'b1, 1'b1, 16};
    tbl[8] = '{1,  1'b1, 1'b1, 1};
    tbl[9] = '{15, 1'b1, 1'b1, 15};

    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive_fifo();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 32'd0);
    chk("rst_last", out_last, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_ren", fifo_ren, 32'd0);

    // Start decision table
    for (int v = 0; v < 10; v++) begin
      reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
      fq.delete();
      for (int k = 0; k < tbl[v].nwords; k++) push_word(w);
      tick();
      reset = 1'b0;
      flush = tbl[v].fl;
      tick();
      flush = 1'b0;
      chk("tbl_busy", busy, {31'b0, tbl[v].exp_busy});
      if (tbl[v].exp_busy) begin
        run_until_idle(60, n);
        chk("tbl_len", n, tbl[v].exp_len);
        chk("tbl_last_idx", last_idx, tbl[v].exp_len);
      end else begin
        repeat (3) tick();
        chk("tbl_stay_idle", busy, 32'd0);
      end
    end

    // Threshold burst: latency, back-to-back beats, last on A4
    do_reset();
    for (int k = 0; k < 4; k++) push_word(a[k]);
    tick();
    chk("thr_busy", busy, 32'd1);
    chk("thr_ren_first", fifo_ren, 32'd1);
    chk("thr_valid_first", out_valid, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("thr_valid", out_valid, 32'd1);
      chk("thr_data", out_data, a[k]);
      chk("thr_last", out_last, {31'b0, (k == 3)});
      chk("thr_ren", fifo_ren, {31'b0, (k < 3)});
    end
    tick();
    chk("thr_busy_done", busy, 32'd0);
    chk("thr_valid_done", out_valid, 32'd0);

    // Backpressure: A1 held while out_ready is low
    do_reset();
    acc_data.delete();
    for (int k = 0; k < 4; k++) push_word(a[k]);
    tick();
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_valid", out_valid, 32'd1);
      chk("bp_data", out_data, a[0]);
      chk("bp_ren", fifo_ren, 32'd0);
      chk("bp_fifo_level", fq.size(), 32'd3);
    end
    out_ready = 1'b1;
    run_until_idle(20, n);
    chk("bp_beats", n, 32'd4);
    for (int k = 0; k < 4; k++) chk("bp_order", acc_data[k], a[k]);

    // Flush below threshold
    do_reset();
    for (int k = 0; k < 3; k++) push_word(w);
    tick();
    tick();
    chk("fl_idle_below_thr", busy, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_busy", busy, 32'd1);
    run_until_idle(20, n);
    chk("fl_beats", n, 32'd3);
    chk("fl_last_idx", last_idx, 32'd3);
    chk("fl_fifo_left", fq.size(), 32'd0);

    // Full FIFO flush: 16 beats
    do_reset();
    for (int k = 0; k < 16; k++) push_word(w);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run_until_idle(60, n);
    chk("full_beats", n, 32'd16);
    chk("full_last_idx", last_idx, 32'd16);
    chk("full_fifo_left", fq.size(), 32'd0);

    // Reset mid-burst
    do_reset();
    for (int k = 0; k < 4; k++) push_word(a[k]);
    tick();
    tick();
    tick();
    chk("mid_beat2", out_data, a[1]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_valid", out_valid, 32'd0);
    chk("mid_busy", busy, 32'd0);
    chk("mid_ren", fifo_ren, 32'd0);
    chk("mid_fifo_left", fq.size(), 32'd2);
    repeat (3) tick();
    chk("mid_no_restart", busy, 32'd0);
    acc_data.delete();
    for (int k = 0; k < 2; k++) push_word(b[k]);
    tick();
    chk("mid_restart", busy, 32'd1);
    run_until_idle(20, n);
    chk("mid_beats", n, 32'd4);
    chk("mid_order0", acc_data[0], a[2]);
    chk("mid_order1", acc_data[1], a[3]);
    chk("mid_order2", acc_data[2], b[0]);
    chk("mid_order3", acc_data[3], b[1]);

    // Flush with an empty FIFO is ignored
    do_reset();
    flush = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("empty_flush_busy", busy, 32'd0);
      chk("empty_flush_ren", fifo_ren, 32'd0);
    end
    flush = 1'b0;

    // Random traffic against the burst model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 19) == 0);
      if (fq.size() < CAP && $urandom_range(0, 2) == 0) push_word(w);
      tick();
    end
    out_ready = 1'b1;
    flush = 1'b0;
    for (int c = 0; c < 300; c++) begin
      flush = m_idle && (fq.size() > 0);
      tick();
      if (m_idle && fq.size() == 0 && !flush) break;
    end
    flush = 1'b0;
    tick();
    chk("rand_drained", {31'b0, (m_idle && fq.size() == 0)}, 32'd1);
    chk("rand_idle", busy, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
